// File: rtl/aes_pkg.sv
// Shared AES round-stage definitions: GF(2^8) helper, FSM encoding and state byte indexing.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MIX  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // State byte i sits at row i%4, column i/4.
    function automatic int byte_idx(input int row, input int col);
        return col * 4 + row;
    endfunction

    // Source byte feeding (row, col) after ShiftRows (inv=0) or InvShiftRows (inv=1).
    function automatic int shift_src(input int row, input int col, input logic inv);
        return inv ? byte_idx(row, (col + 4 - row) % 4) : byte_idx(row, (col + row) % 4);
    endfunction

endpackage

// File: rtl/aes_shift_mix_round_if.sv
// Upstream (state/key/flags) and downstream (round result) valid/ready bundle of the round stage.
interface aes_shift_mix_round_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] round_key;
    logic         mode;
    logic         last_round;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    modport master (
        output in_valid, state_in, round_key, mode, last_round, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, round_key, mode, last_round, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/aes_mix_col.sv
// One-column (Inv)MixColumns, purely combinational; row r of the column is byte [8r+:8].
module aes_mix_col
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        mode,
    output logic [31:0] col_out
);

    logic [3:0][7:0] a;
    logic [3:0][7:0] x2;
    logic [3:0][7:0] x4;
    logic [3:0][7:0] x8;

    always_comb begin
        a       = col_in;
        x2      = '0;
        x4      = '0;
        x8      = '0;
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
        end
        // Decrypt coefficients built from x8/x4/x2: 0E, 0B, 0D, 09.
        for (int r = 0; r < 4; r++) begin
            if (mode)
                col_out[8*r +: 8] = (x8[r] ^ x4[r] ^ x2[r])
                                  ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                                  ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                                  ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
            else
                col_out[8*r +: 8] = x2[r]
                                  ^ (x2[(r+1)%4] ^ a[(r+1)%4])
                                  ^ a[(r+2)%4]
                                  ^ a[(r+3)%4];
        end
    end

endmodule

// File: rtl/aes_shift_mix_round.sv
// (Inv)ShiftRows -> (Inv)MixColumns one column/cycle -> AddRoundKey; one block in flight.
// out_valid 1 cycle after accept (last round) or 5 (normal); result held while out_ready=0.
module aes_shift_mix_round
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    aes_shift_mix_round_if.slave bus
);

    logic [1:0]   fsm;
    logic [1:0]   col;
    logic [127:0] data;
    logic [127:0] key;
    logic         mode_q;
    logic [127:0] shifted;
    logic [31:0]  mixed;

    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[byte_idx(r, c)*8 +: 8] = bus.state_in[shift_src(r, c, bus.mode)*8 +: 8];
            end
        end
    end

    aes_mix_col u_mix_col (
        .col_in  (data[{col, 5'b0} +: 32]),
        .mode    (mode_q),
        .col_out (mixed)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm    <= ST_IDLE;
            col    <= 2'd0;
            data   <= '0;
            key    <= '0;
            mode_q <= 1'b0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        mode_q <= bus.mode;
                        key    <= bus.round_key;
                        col    <= 2'd0;
                        if (bus.last_round) begin
                            data <= shifted ^ bus.round_key;
                            fsm  <= ST_DONE;
                        end else begin
                            data <= shifted;
                            fsm  <= ST_MIX;
                        end
                    end
                end
                ST_MIX: begin
                    data[{col, 5'b0} +: 32] <= mixed ^ key[{col, 5'b0} +: 32];
                    col                     <= col + 2'd1;
                    if (col == 2'd3)
                        fsm <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready)
                        fsm <= ST_IDLE;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (fsm == ST_IDLE);
    assign bus.out_valid = (fsm == ST_DONE);
    assign bus.state_out = data;

endmodule

// File: tb/tb_aes_shift_mix_round.sv
// Scoreboard bench for aes_shift_mix_round: directed FIPS-197 vectors plus randomized enc/dec traffic.
module tb_aes_shift_mix_round;

    localparam int BUDGET = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_shift_mix_round_if bus();

    aes_shift_mix_round dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mc_in;
    logic [31:0] mc_out;
    logic        mc_mode;

    aes_mix_col u_mc (
        .col_in  (mc_in),
        .mode    (mc_mode),
        .col_out (mc_out)
    );

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    logic [127:0] fips_s, fips_k, fips_enc, fips_lr;

    // Literal written byte0 first; byte i lands at [8i+:8].
    function automatic logic [127:0] pk(input logic [127:0] be);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = be[8*(15-i) +: 8];
        return o;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                           input logic m, input logic lr);
        logic [7:0]   sh [4][4];
        logic [7:0]   cf [4];
        logic [7:0]   v;
        logic [127:0] o;
        int           src;
        if (m) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else   cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = m ? (c + 4 - r) % 4 : (c + r) % 4;
                sh[r][c] = s[(src*4 + r)*8 +: 8];
            end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (lr) v = sh[r][c];
                else begin
                    v = 8'h00;
                    for (int j = 0; j < 4; j++) v = v ^ gmul(cf[(j - r + 4) % 4], sh[j][c]);
                end
                o[(c*4 + r)*8 +: 8] = v ^ k[(c*4 + r)*8 +: 8];
            end
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one block, waits for the accept edge, pushes its expectation, then scrambles the inputs.
    task automatic send(input logic [127:0] s, input logic [127:0] k, input logic m, input logic lr,
                        input logic [127:0] exp);
        int n = 0;
        bus.state_in   = s;
        bus.round_key  = k;
        bus.mode       = m;
        bus.last_round = lr;
        bus.in_valid   = 1'b1;
        while (!bus.in_ready && n < BUDGET) begin
            step();
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_accept: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
        step();
        exp_q.push_back(exp);
        bus.in_valid   = 1'b0;
        bus.state_in   = {$urandom, $urandom, $urandom, $urandom};
        bus.round_key  = {$urandom, $urandom, $urandom, $urandom};
        bus.mode       = ~m;
        bus.last_round = ~lr;
    endtask

    // Called right after send(): counts cycles from the accept cycle to out_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < BUDGET) begin
            step();
            lat++;
        end
    endtask

    task automatic recv(input string name, input int rdy_pct);
        logic [127:0] exp;
        for (int n = 0; n < BUDGET; n++) begin
            bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s: unexpected output %h, scoreboard empty", name, bus.state_out);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.state_out !== exp) begin
                        errors++;
                        $display("FAIL %s: state_out=%h expected %h", name, bus.state_out, exp);
                    end
                end
                step();
                return;
            end
            step();
        end
        checks++;
        errors++;
        $display("FAIL %s: no output within %0d cycles, expected one", name, BUDGET);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.state_in   = fips_s;
        bus.round_key  = fips_k;
        bus.mode       = 1'b0;
        bus.last_round = 1'b1;
        bus.out_ready  = 1'b1;
        step();
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_valid_ignored: out_valid=%b required 0", bus.out_valid);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.state_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_state_out: state_out=%h required 0", bus.state_out);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_fips_enc();
        int lat;
        bus.out_ready = 1'b1;
        send(fips_s, fips_k, 1'b0, 1'b0, fips_enc);
        wait_valid(lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL enc_latency: latency=%0d required 5", lat);
        end
        recv("fips_enc", 100);
    endtask

    task automatic test_mix_col();
        mc_in   = 32'h455313db;
        mc_mode = 1'b0;
        #1;
        checks++;
        if (mc_out !== 32'hbca14d8e) begin
            errors++;
            $display("FAIL mix_col_enc: col_out=%h expected bca14d8e", mc_out);
        end
        mc_in   = 32'hbca14d8e;
        mc_mode = 1'b1;
        #1;
        checks++;
        if (mc_out !== 32'h455313db) begin
            errors++;
            $display("FAIL mix_col_dec: col_out=%h expected 455313db", mc_out);
        end
    endtask

    task automatic test_last_round();
        int lat;
        bus.out_ready = 1'b1;
        send(fips_s, 128'h0, 1'b0, 1'b1, fips_lr);
        wait_valid(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL last_latency: latency=%0d required 1", lat);
        end
        recv("last_enc", 100);
        send(fips_lr, 128'h0, 1'b1, 1'b1, fips_s);
        wait_valid(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL last_dec_latency: latency=%0d required 1", lat);
        end
        recv("last_dec", 100);
    endtask

    task automatic test_back_pressure();
        int lat;
        int bad_valid = 0;
        int bad_data = 0;
        int bad_rdy = 0;
        logic [127:0] exp;
        bus.out_ready = 1'b0;
        send(fips_s, fips_k, 1'b0, 1'b0, fips_enc);
        wait_valid(lat);
        bus.in_valid = 1'b1;
        bus.state_in = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b1) bad_valid++;
            if (bus.state_out !== fips_enc) bad_data++;
            if (bus.in_ready !== 1'b0) bad_rdy++;
            step();
        end
        checks++;
        if (bad_valid != 0) begin
            errors++;
            $display("FAIL bp_valid: out_valid dropped in %0d cycles, required 0", bad_valid);
        end
        checks++;
        if (bad_data != 0) begin
            errors++;
            $display("FAIL bp_data: state_out changed in %0d cycles, required 0", bad_data);
        end
        checks++;
        if (bad_rdy != 0) begin
            errors++;
            $display("FAIL bp_in_ready: in_ready high in %0d cycles, required 0", bad_rdy);
        end
        bus.out_ready = 1'b1;
        exp = exp_q.pop_front();
        checks++;
        if (bus.state_out !== exp) begin
            errors++;
            $display("FAIL bp_result: state_out=%h expected %h", bus.state_out, exp);
        end
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
        bus.in_valid = 1'b0;
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_second_accept: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_mix();
        int seen = 0;
        bus.out_ready = 1'b1;
        send(fips_s, fips_k, 1'b0, 1'b0, fips_enc);
        exp_q.delete();
        step();
        step();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_idle: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_no_output: out_valid seen %0d cycles, required 0", seen);
        end
        send(fips_s, fips_k, 1'b0, 1'b0, fips_enc);
        recv("mid_reset_next", 100);
    endtask

    task automatic test_random(input int nblk);
        logic [127:0] s, k;
        logic m, lr;
        for (int b = 0; b < nblk; b++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) step();
            s  = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            m  = ($urandom_range(0, 1) == 1);
            lr = ($urandom_range(0, 3) == 0);
            send(s, k, m, lr, model(s, k, m, lr));
            recv("random", 60);
        end
    endtask

    initial begin
        fips_s   = pk(128'hd42711aee0bf98f1b8b45de51e415230);
        fips_k   = pk(128'ha0fafe1788542cb123a339392a6c7605);
        fips_enc = pk(128'ha49c7ff2689f352b6b5bea43026a5049);
        fips_lr  = pk(128'hd4bf5d30e0b452aeb84111f11e2798e5);
        bus.in_valid   = 1'b0;
        bus.state_in   = '0;
        bus.round_key  = '0;
        bus.mode       = 1'b0;
        bus.last_round = 1'b0;
        bus.out_ready  = 1'b0;
        mc_in          = '0;
        mc_mode        = 1'b0;

        test_reset();
        test_mix_col();
        test_fips_enc();
        test_last_round();
        test_back_pressure();
        test_reset_mid_mix();
        test_random(1500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
